// File: rtl/instruction_fetch_memory_pkg.sv
// Shared definitions for the instruction fetch memory: FSM encoding and the
// no-op instruction returned on misaligned fetches.
package instruction_fetch_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_t;

    localparam int          CNT_WIDTH = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Little-endian assembly of four byte lanes into one instruction word.
    function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/instruction_fetch_memory_byte_ram.sv
// Byte-wide program store: one synchronous write port and four combinational
// read lanes at raddr..raddr+3, wrapping at the top of the array.
module byte_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [7:0]            lane0,
    output logic [7:0]            lane1,
    output logic [7:0]            lane2,
    output logic [7:0]            lane3
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr1;
    logic [ADDR_WIDTH-1:0] addr2;
    logic [ADDR_WIDTH-1:0] addr3;

    // No reset on the array so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign addr1 = raddr + ADDR_WIDTH'(1);
    assign addr2 = raddr + ADDR_WIDTH'(2);
    assign addr3 = raddr + ADDR_WIDTH'(3);

    assign lane0 = mem[raddr];
    assign lane1 = mem[addr1];
    assign lane2 = mem[addr2];
    assign lane3 = mem[addr3];

endmodule

// File: rtl/instruction_fetch_memory.sv
// Instruction fetch memory: byte-loadable program store with a fixed-latency
// word fetch port (IDLE/WAIT/RESP sequencer and wait-state down-counter).
module instruction_fetch_memory
    import instruction_fetch_memory_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_byte,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           data_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  misaligned
);

    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : CNT_WIDTH'(WAIT_STATES - 1);

    fetch_state_t          state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            lane0;
    logic [7:0]            lane1;
    logic [7:0]            lane2;
    logic [7:0]            lane3;
    logic [31:0]           rd_word;
    logic                  ram_we;

    assign ram_we  = load_en & ~reset;
    // Zero-wait fetches read straight from the request address; waited ones from the capture.
    assign rd_addr = (state == ST_WAIT) ? cap_addr : addr;
    assign rd_word = pack_word(lane0, lane1, lane2, lane3);

    byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_byte_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_byte),
        .raddr (rd_addr),
        .lane0 (lane0),
        .lane1 (lane1),
        .lane2 (lane2),
        .lane3 (lane3)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cap_addr   <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            valid      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (req) begin
                        cap_addr <= addr;
                        if (addr[1:0] != 2'b00) begin
                            state      <= ST_RESP;
                            valid      <= 1'b1;
                            misaligned <= 1'b1;
                            data_out   <= NOP_WORD;
                            busy       <= 1'b0;
                        end else if (WAIT_STATES == 0) begin
                            state    <= ST_RESP;
                            valid    <= 1'b1;
                            data_out <= rd_word;
                            busy     <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state    <= ST_RESP;
                        valid    <= 1'b1;
                        data_out <= rd_word;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench: one zero-wait and one three-wait instance sharing the
// clock, reset and load port; expected words are hand-computed constants.
module tb_instruction_fetch_memory;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_byte = '0;

    logic          req0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [31:0]   data0;
    logic          valid0, busy0, mis0;

    logic          req3 = 1'b0;
    logic [AW-1:0] addr3 = '0;
    logic [31:0]   data3;
    logic          valid3, busy3, mis3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_memory #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_byte(load_byte), .req(req0), .addr(addr0), .data_out(data0),
        .valid(valid0), .busy(busy0), .misaligned(mis0)
    );

    instruction_fetch_memory #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_byte(load_byte), .req(req3), .addr(addr3), .data_out(data3),
        .valid(valid3), .busy(busy3), .misaligned(mis3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] b);
        load_en   = 1'b1;
        load_addr = a;
        load_byte = b;
        tick();
        load_en = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [12];
        int n;
        prog = '{8'hB3, 8'h81, 8'h20, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00};

        #2;
        chk("rst_data0", data0, 32'h0);
        chk("rst_flags0", {29'h0, valid0, busy0, mis0}, 32'h0);
        chk("rst_flags3", {29'h0, valid3, busy3, mis3}, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) load(AW'(i), prog[i]);

        // Zero-wait aligned fetch
        req0 = 1'b1; addr0 = '0;
        tick();
        chk("ws0_data", data0, 32'h002081B3);
        chk("ws0_flags", {29'h0, valid0, busy0, mis0}, 32'b100);
        req0 = 1'b0;
        tick();
        chk("ws0_hold_data", data0, 32'h002081B3);
        chk("ws0_idle_flags", {29'h0, valid0, busy0, mis0}, 32'b000);

        // Misaligned fetch returns the no-op
        req0 = 1'b1; addr0 = AW'(2);
        tick();
        chk("mis_data", data0, 32'h00000013);
        chk("mis_flags", {29'h0, valid0, busy0, mis0}, 32'b101);
        req0 = 1'b0;
        tick();
        chk("mis_clear", {29'h0, valid0, busy0, mis0}, 32'b000);

        // Back-to-back fetches
        req0 = 1'b1; addr0 = '0;
        tick();
        chk("b2b_first", data0, 32'h002081B3);
        chk("b2b_first_v", {31'h0, valid0}, 32'h1);
        addr0 = AW'(4);
        tick();
        chk("b2b_second", data0, 32'h00000113);
        chk("b2b_second_v", {31'h0, valid0}, 32'h1);
        req0 = 1'b0;
        tick();
        chk("b2b_end_v", {31'h0, valid0}, 32'h0);

        // Three wait states
        req3 = 1'b1; addr3 = '0;
        tick();
        req3 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("ws3_busy%0d", c), {30'h0, valid3, busy3}, 32'b01);
            if (c < 3) tick();
        end
        tick();
        chk("ws3_resp", {29'h0, valid3, busy3, mis3}, 32'b100);
        chk("ws3_data", data3, 32'h002081B3);
        tick();
        chk("ws3_after", {31'h0, valid3}, 32'h0);

        // Reset in the second WAIT cycle aborts; a load during reset is dropped
        req3 = 1'b1; addr3 = '0;
        tick();
        req3 = 1'b0;
        tick();
        chk("abort_in_wait", {31'h0, busy3}, 32'h1);
        reset = 1'b1; load_en = 1'b1; load_addr = AW'(8); load_byte = 8'hAA;
        #1;
        chk("abort_data", data3, 32'h0);
        chk("abort_flags", {29'h0, valid3, busy3, mis3}, 32'b000);
        tick();
        reset = 1'b0; load_en = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (valid3) n++;
            tick();
        end
        chk("abort_no_valid", 32'(n), 32'h0);

        req3 = 1'b1; addr3 = '0;
        tick();
        req3 = 1'b0;
        n = 0;
        while (!valid3 && n < 10) begin
            tick();
            n++;
        end
        chk("post_reset_lat", 32'(n), 32'd3);
        chk("post_reset_data", data3, 32'h002081B3);

        req0 = 1'b1; addr0 = AW'(8);
        tick();
        req0 = 1'b0;
        chk("load_in_reset", data0, 32'h0);
        chk("load_in_reset_v", {31'h0, valid0}, 32'h1);
        tick();

        // Load write on the RESP-entry edge is not seen by that response
        req0 = 1'b1; addr0 = '0;
        load_en = 1'b1; load_addr = '0; load_byte = 8'hFF;
        tick();
        load_en = 1'b0;
        chk("wr_same_edge", data0, 32'h002081B3);
        tick();
        chk("wr_next_fetch", data0, 32'h002081FF);
        req0 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
